// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS dataflow AXIS deadlock monitor.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package hls_deadlock_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SUSPECT   = 2'd1,
      CONFIRMED = 2'd2
   } dl_state_t;

   localparam int DEF_CNT_W = 16;

   // Upper bound on vector width accepted by lowest_set_idx; callers zero-extend.
   localparam int MAX_VEC_W = 64;

   // Index of the lowest set bit, 0 when no bit is set.
   function automatic int lowest_set_idx(input logic [MAX_VEC_W-1:0] vec);
      int idx;
      idx = 0;
      for (int i = MAX_VEC_W - 1; i >= 0; i--) begin
         if (vec[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/hls_deadlock_persist_cnt.sv
// Persistence counter: counts consecutive qualified-hit cycles, flags the terminal one.
// Latency: done is combinational on qhit and the registered count. Backpressure: none.
// Count restarts whenever qhit drops, while restart is held, or on the terminal cycle.
module hls_deadlock_persist_cnt
   import hls_deadlock_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             qhit,
   input  logic             restart,
   input  logic [CNT_W-1:0] persist_cycles,
   output logic             done
);

   logic [CNT_W-1:0] pcnt;

   // pcnt holds the number of qualified cycles already seen, so the terminal
   // cycle is the one where the stored count reaches persist_cycles-1.
   assign done = qhit & ~restart & (pcnt == (persist_cycles - CNT_W'(1)));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pcnt <= '0;
      end else if (restart || !qhit || done) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hls_deadlock_axis_monitor.sv
// AXIS deadlock monitor for one HLS dataflow process: raw block flag plus filtered sticky report.
// Latency: block 1 cycle after hit; confirm PERSIST_CYCLES edges after first qualified hit.
// Backpressure: none (pure observer). Optional snapshot register: HLS_DEADLOCK_SNAPSHOT_EN.
module hls_deadlock_axis_monitor
   import hls_deadlock_pkg::*;
#(
   parameter int                  NUM_AXIS       = 7,
   parameter int                  NUM_INST       = 41,
   parameter int                  NUM_BLK        = 30,
   parameter logic [NUM_AXIS-1:0] WATCH_MASK     = 7'b0111000,
   parameter int                  PERSIST_CYCLES = 16,
   parameter int                  CNT_W          = DEF_CNT_W,
   parameter int                  IDX_W          = $clog2(NUM_AXIS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                clear,
   input  logic [NUM_AXIS-1:0] axis_block_sigs,
   input  logic [NUM_INST-1:0] inst_idle_sigs,
   input  logic [NUM_BLK-1:0]  inst_block_sigs,
   output logic                block,
   output logic                block_confirmed,
   output logic [IDX_W-1:0]    block_idx,
   output logic [CNT_W-1:0]    block_cycles,
   output logic [NUM_AXIS-1:0] block_snapshot
);

   logic [NUM_AXIS-1:0] masked;
   logic                hit;
   logic                all_idle;
   logic                qhit;
   logic                done;
   logic                restart;
   logic                capture;
   logic                count_en;
   dl_state_t           st;
   dl_state_t           st_nxt;

   // Port kept only for drop-in compatibility with the generated wrappers.
   logic unused_inst_block;
   assign unused_inst_block = ^inst_block_sigs;

   assign masked   = axis_block_sigs & WATCH_MASK;
   assign hit      = |masked;
   assign all_idle = &inst_idle_sigs;
   // A region that is entirely idle is drained, not deadlocked.
   assign qhit     = hit & ~all_idle & enable;

   hls_deadlock_persist_cnt #(
      .CNT_W (CNT_W)
   ) u_persist (
      .clock          (clock),
      .reset          (reset),
      .qhit           (qhit),
      .restart        (restart),
      .persist_cycles (CNT_W'(PERSIST_CYCLES)),
      .done           (done)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st <= IDLE;
      end else begin
         st <= st_nxt;
      end
   end

   always_comb begin
      st_nxt = st;
      case (st)
         IDLE: begin
            if (qhit) st_nxt = done ? CONFIRMED : SUSPECT;
         end
         SUSPECT: begin
            if (!qhit)     st_nxt = IDLE;
            else if (done) st_nxt = CONFIRMED;
         end
         CONFIRMED: begin
            if (clear) st_nxt = IDLE;
         end
         default: st_nxt = IDLE;
      endcase
   end

   always_comb begin
      restart         = (st == CONFIRMED);
      block_confirmed = (st == CONFIRMED);
      capture         = (st != CONFIRMED) && (st_nxt == CONFIRMED);
      // The clear cycle itself is not counted so the final duration stays readable.
      count_en        = (st == CONFIRMED) && !clear && hit;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         block <= 1'b0;
      end else begin
         block <= hit;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         block_idx    <= '0;
         block_cycles <= '0;
      end else if (capture) begin
         block_idx    <= IDX_W'(lowest_set_idx(MAX_VEC_W'(masked)));
         block_cycles <= CNT_W'(1);
      end else if (count_en && (block_cycles != {CNT_W{1'b1}})) begin
         block_cycles <= block_cycles + CNT_W'(1);
      end
   end

`ifdef HLS_DEADLOCK_SNAPSHOT_EN
   logic [NUM_AXIS-1:0] snap_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         snap_q <= '0;
      end else if (capture) begin
         snap_q <= masked;
      end
   end

   assign block_snapshot = snap_q;
`else
   assign block_snapshot = '0;
`endif

endmodule

// File: doc/hls_deadlock_axis_monitor.md
# hls_deadlock_axis_monitor

Parametrised AXI-Stream deadlock monitor for the HLS dataflow regions of the stereo pipeline. One instance watches one dataflow process: a masked subset of the region's AXIS block signals. It keeps the per-cycle registered `block` flag that the region-level deadlock detector already consumes. It adds persistence filtering, whole-region idle suppression, a sticky confirmed-deadlock report, first-offender capture and a stall-duration counter. It sits between the generated per-process block signals and the region-level deadlock OR tree and debug registers.

## Interface
Parameters:
- `NUM_AXIS`, 7: width of `axis_block_sigs`.
- `NUM_INST`, 41: width of `inst_idle_sigs`.
- `NUM_BLK`, 30: width of `inst_block_sigs`.
- `WATCH_MASK`, 7'b0111000: AXIS channels owned by this monitor. Must be non-zero.
- `PERSIST_CYCLES`, 16: consecutive qualified-hit cycles required to confirm. Legal range 1..2^CNT_W-1.
- `CNT_W`, 16: width of the persistence and stall counters.
- `IDX_W`, $clog2(NUM_AXIS): width of `block_idx`.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high. All state clears immediately on assertion.
- `enable` in 1: monitoring enable for the confirm path.
- `clear` in 1: one-cycle pulse that releases a confirmed report.
- `axis_block_sigs` in NUM_AXIS: per-channel AXIS blocked flags.
- `inst_idle_sigs` in NUM_INST: per-process idle flags.
- `inst_block_sigs` in NUM_BLK: unused by logic. Kept for port compatibility.
- `block` out 1: registered raw hit.
- `block_confirmed` out 1: sticky deadlock report.
- `block_idx` out IDX_W: lowest watched blocked channel, captured at confirmation.
- `block_cycles` out CNT_W: saturating count of hit cycles since confirmation.
- `block_snapshot` out NUM_AXIS: masked `axis_block_sigs` captured at confirmation (see Configuration).

## Operation
- `hit` = |(axis_block_sigs & WATCH_MASK).
- `qhit` = hit & ~(&inst_idle_sigs) & enable.
- `block` is the registered `hit`, with no idle or enable gating. This preserves the behaviour of the existing per-process monitors.

State machine `st`, with persistence counter `pcnt`:
- IDLE:
  - If qhit and PERSIST_CYCLES==1, go to CONFIRMED and capture.
  - Else if qhit, go to SUSPECT with pcnt=1.
  - Else stay in IDLE with pcnt=0.
- SUSPECT:
  - If ~qhit, go to IDLE with pcnt=0.
  - Else if pcnt==PERSIST_CYCLES-1, go to CONFIRMED and capture.
  - Else pcnt++.
- CONFIRMED:
  - Sticky. Leaves only on `clear`, to IDLE.
  - `enable` low and idle suppression do not release it.
- Capture (on the edge entering CONFIRMED):
  - `block_idx` = lowest index i with axis_block_sigs[i] & WATCH_MASK[i].
  - `block_cycles` = 1.
  - Snapshot is taken if compiled in.
- In CONFIRMED, `block_cycles` increments on each `hit` cycle and saturates at 2^CNT_W-1.
- `enable` low in IDLE or SUSPECT forces IDLE and sets pcnt=0.
- `clear` while in IDLE or SUSPECT: ignored.
- `clear` coincident with `hit` in CONFIRMED: `clear` wins and the state goes to IDLE. Re-arming starts at the next qhit cycle.
- `block_idx`, `block_cycles` and the snapshot hold their values after `clear` until the next capture.

## Timing
- Reset value of all outputs is 0. `st` resets to IDLE and `pcnt` to 0.
- `block` latency is 1 cycle after `hit`.
- For first qhit at edge k with qhit sustained, `block_confirmed` is high after edge k+PERSIST_CYCLES-1. For PERSIST_CYCLES==1, it is high after edge k.
- A one-cycle qhit dropout anywhere in SUSPECT restarts the count from zero.
- `block_confirmed` falls 1 cycle after `clear` is sampled.
- Reset asserted mid-SUSPECT or in CONFIRMED clears everything asynchronously. No report survives.

## Configuration
- `HLS_DEADLOCK_SNAPSHOT_EN`:
  - Defined: a NUM_AXIS-bit snapshot register captures axis_block_sigs & WATCH_MASK on entry to CONFIRMED and drives `block_snapshot`.
  - Undefined: no register is built and `block_snapshot` is tied to 0.

## Structure
- Shared package `hls_deadlock_pkg`:
  - State enum `dl_state_t` (IDLE, SUSPECT, CONFIRMED).
  - Function `lowest_set_idx`.
  - Default CNT_W.
- One sub-module, `hls_deadlock_persist_cnt`: pcnt plus the terminal-count compare. Inputs are qhit, restart and PERSIST_CYCLES. Output is `done`.

## Test plan
- WATCH_MASK=7'b0111000, PERSIST_CYCLES=4, axis bit 4 high for 4 cycles: `block` is high from cycle 2. `block_confirmed` is high after the 4th edge. `block_idx`=4.
- Same mask, bit 3 high for 3 cycles, low for 1, high for 4: confirm after the second burst's 4th edge only. `block_idx`=3.
- Bit 0 (unwatched) high for 100 cycles: `block`=0, `block_confirmed`=0.
- Bit 5 high with all inst_idle_sigs high for 50 cycles: `block`=1 and `block_confirmed`=0.
- Confirmed, hit held for 10 more cycles, then `clear` pulsed with hit still high: `block_cycles`=11 holds. `block_confirmed` drops 1 cycle after `clear` and re-confirms 4 edges later. With CNT_W=4 and hit held, `block_cycles` saturates at 15.
- Reset asserted mid-SUSPECT (pcnt=2) and in CONFIRMED: all outputs are 0 immediately. With HLS_DEADLOCK_SNAPSHOT_EN, `block_snapshot`=7'b0011000 after confirming on bits 3 and 4.
